// File: rtl/pipe_pkg.sv
// Purpose : shared types and helpers for the pipeline hazard sequencer.
// Latency : n/a (types, constants and a combinational compare helper only).
// Backpr. : n/a.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_BUSY  = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   // Forwarding mux selects for the EX-stage ALU operands
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // A producer matches a consumer only if it writes a non-zero register.
   // r0 is hardwired to zero and must never be forwarded or stalled on.
   function automatic logic fwd_hit(input logic       we,
                                    input logic [4:0] dst,
                                    input logic [4:0] src);
      return we && (dst != 5'd0) && (dst == src);
   endfunction

endpackage

// File: rtl/hz_md_timer.sv
// Purpose : mult/div occupancy counter; load on issue, count down per unfrozen cycle.
// Latency : o_busy rises the cycle after i_load and stays high for LATENCY cycles.
// Backpr. : i_freeze holds the count (DMEM wait); no other flow control.
// Ports   : clk/rst, i_load (issue), i_freeze (hold), o_busy, o_last (busy with count 0).
module hz_md_timer #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_freeze,
   output logic o_busy,
   output logic o_last
);

   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         // A load on the final busy cycle restarts the window back-to-back
         r_cnt  <= CW'(LATENCY - 1);
         r_busy <= 1'b1;
      end else if (r_busy && !i_freeze) begin
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_busy = r_busy;
   assign o_last = r_busy && (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : 5-stage pipeline hazard sequencer: stalls, flushes, forwarding, mult/div window, DMEM freeze.
// Latency : all stall/flush/forward outputs are combinational (0-cycle) from inputs and registered state.
// Backpr. : DMEM not-ready freezes all four pipe registers; ID hazards hold PC/IF-ID and bubble ID-EX.
// Ports   : ID/EX/MEM/WB register indices and controls in; Stall*/Flush*/Forward* out,
//           plus MdBusy, sticky MemTimeout and a saturating StallCycles counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY  = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic [4:0]  RsE,
   input  logic [4:0]  RtE,
   input  logic [4:0]  WriteRegE,
   input  logic [4:0]  WriteRegM,
   input  logic [4:0]  WriteRegW,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemtoRegE,
   input  logic        MemtoRegM,
   input  logic        BranchD,
   input  logic        BranchTakenD,
   input  logic        MdStartD,
   input  logic        MdReadD,
   input  logic        MemReqM,
   input  logic        DmemReadyM,
   output logic        StallF,
   output logic        IF_Stall,
   output logic        StallE,
   output logic        StallM,
   output logic        IF_Flush,
   output logic        FlushE,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        ForwardAD,
   output logic        ForwardBD,
   output logic        MdBusy,
   output logic        MemTimeout,
   output logic [31:0] StallCycles
);

   state_t      r_state;
   state_t      r_saved;
   state_t      w_eff_state;
   logic [31:0] r_wait_cnt;
   logic        r_mem_timeout;
   logic [31:0] r_stall_cycles;

   logic w_freeze, w_lwstall, w_brstall, w_mdstall, w_idstall, w_if_stall;
   logic w_md_load, w_md_busy, w_md_last;

   assign w_freeze  = MemReqM && !DmemReadyM;

   assign w_lwstall = MemtoRegE && (fwd_hit(1'b1, WriteRegE, RsD) || fwd_hit(1'b1, WriteRegE, RtD));

   // Branches compare in ID: wait for an ALU result still in EX, or a load still in MEM
   assign w_brstall = BranchD &&
                      (fwd_hit(RegWriteE, WriteRegE, RsD) || fwd_hit(RegWriteE, WriteRegE, RtD) ||
                       fwd_hit(MemtoRegM, WriteRegM, RsD) || fwd_hit(MemtoRegM, WriteRegM, RtD));

   // The final busy cycle is not a stall: HI/LO is ready at its end and a new issue may overlap it
   assign w_mdstall = w_md_busy && !w_md_last && (MdStartD || MdReadD);

   assign w_idstall  = w_lwstall || w_brstall || w_mdstall;
   assign w_if_stall = w_freeze || w_idstall;
   assign w_md_load  = MdStartD && !w_if_stall;

   // While frozen the FSM sits in MEM_WAIT; the unfrozen cycle resumes from the saved state
   assign w_eff_state = (r_state == MEM_WAIT) ? r_saved : r_state;

   hz_md_timer #(
      .LATENCY (MD_LATENCY)
   ) u_md_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_md_load),
      .i_freeze (w_freeze),
      .o_busy   (w_md_busy),
      .o_last   (w_md_last)
   );

   always_comb begin
      StallF    = 1'b0;
      IF_Stall  = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      IF_Flush  = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      if (!rst) begin
         StallF   = w_if_stall;
         IF_Stall = w_if_stall;
         StallE   = w_freeze;
         StallM   = w_freeze;
         FlushE   = w_idstall && !w_freeze;
         IF_Flush = BranchTakenD && !w_if_stall;

         if (fwd_hit(RegWriteM, WriteRegM, RsE))      ForwardAE = FWD_MEM;
         else if (fwd_hit(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_WB;

         if (fwd_hit(RegWriteM, WriteRegM, RtE))      ForwardBE = FWD_MEM;
         else if (fwd_hit(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_WB;

         ForwardAD = fwd_hit(RegWriteM, WriteRegM, RsD);
         ForwardBD = fwd_hit(RegWriteM, WriteRegM, RtD);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= RUN;
         r_saved        <= RUN;
         r_wait_cnt     <= '0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         if (w_if_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end

         if (w_freeze) begin
            if (r_state != MEM_WAIT) begin
               r_saved <= r_state;
            end
            r_state <= MEM_WAIT;
            if (r_wait_cnt < 32'(MEM_TIMEOUT)) begin
               r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (r_wait_cnt >= 32'(MEM_TIMEOUT - 1)) begin
               r_mem_timeout <= 1'b1;
            end
         end else begin
            r_wait_cnt <= '0;
            case (w_eff_state)
               MD_BUSY: r_state <= (w_md_load || !w_md_last) ? MD_BUSY : RUN;
               default: r_state <= w_md_load ? MD_BUSY : RUN;
            endcase
         end
      end
   end

   assign MdBusy      = w_md_busy;
   assign MemTimeout  = r_mem_timeout;
   assign StallCycles = r_stall_cycles;

endmodule
